// File: rtl/layer_scheduler.sv
// layer_scheduler
// Time-multiplexed sequencer for one fully-connected layer. A single MAC walks
// every output neuron: it reads the neuron's weights from an external
// synchronous weight memory and accumulates w*in. It then saturates and biases
// the sum into one shared sigmoid, and captures each result into out_vec.
//
// Optional build macro: LAYER_SCHED_ABORT_EN adds an 'abort' input. When abort
// is high in any non-IDLE state, the FSM returns to IDLE on the next edge
// without pulsing done.
module layer_scheduler #(
  parameter int LENGHT_I = 2,
  parameter int LENGHT_O = 1,
  parameter int WIDTH_W  = 9,
  parameter int WIDTH_I  = 1,
  parameter int WIDTH_SM = 8,
  parameter int WIDTH_O  = 10,
  parameter int ADDR_W   = (LENGHT_I * LENGHT_O > 1) ? $clog2(LENGHT_I * LENGHT_O) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
`ifdef LAYER_SCHED_ABORT_EN
  input  logic                         abort,
`endif
  input  logic [LENGHT_I*WIDTH_I-1:0]  in_vec,
  output logic                         w_rd_en,
  output logic [ADDR_W-1:0]            w_addr,
  input  logic signed [WIDTH_W-1:0]    w_data,
  output logic [WIDTH_SM-1:0]          sig_x,
  input  logic [WIDTH_O-1:0]           sig_f,
  output logic [LENGHT_O*WIDTH_O-1:0]  out_vec,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
);

  // Counter widths (at least one bit even for single-element dimensions)
  localparam int IW = (LENGHT_I > 1) ? $clog2(LENGHT_I) : 1;
  localparam int OW = (LENGHT_O > 1) ? $clog2(LENGHT_O) : 1;
  // Product and accumulator widths; the accumulator is sized so it cannot overflow
  localparam int PW = WIDTH_W + WIDTH_I + 1;
  localparam int AW = PW + $clog2(LENGHT_I);
  // Comparison width wide enough for both the accumulator and the clamp limits
  localparam int CW = ((AW > WIDTH_SM) ? AW : WIDTH_SM) + 1;
  localparam logic signed [CW-1:0] SAT_MAX = CW'((64'sd1 <<< (WIDTH_SM - 1)) - 64'sd1);
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_ACT,
    S_DONE
  } state_t;

  state_t                        state;
  logic [LENGHT_I*WIDTH_I-1:0]   in_reg;
  logic [IW-1:0]                 i_cnt;
  logic [OW-1:0]                 o_cnt;
  logic signed [AW-1:0]          acc;
  // rd_valid/rd_idx track which read (if any) returns data in the current cycle
  logic                          rd_valid;
  logic [IW-1:0]                 rd_idx;

  logic [WIDTH_I-1:0]            elem_arr [LENGHT_I];
  logic [WIDTH_I-1:0]            elem;
  logic signed [PW-1:0]          w_ext;
  logic signed [PW-1:0]          x_ext;
  logic signed [PW-1:0]          prod;
  logic signed [AW-1:0]          acc_sum;
  logic signed [CW-1:0]          acc_wide;
  logic signed [CW-1:0]          sat_val;
  logic [WIDTH_SM-1:0]           sig_next;
  logic                          last_i;
  logic                          last_o;
  logic                          abort_hit;

`ifdef LAYER_SCHED_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Split the captured input vector into its elements
  generate
    for (genvar gi = 0; gi < LENGHT_I; gi++) begin : g_elem
      assign elem_arr[gi] = in_reg[gi*WIDTH_I +: WIDTH_I];
    end
  endgenerate

  // Select the input element paired with the weight arriving this cycle
  always_comb begin
    elem = elem_arr[0];
    for (int k = 0; k < LENGHT_I; k++) begin
      if (rd_idx == IW'(k)) begin
        elem = elem_arr[k];
      end
    end
  end

  // MAC datapath, clamp, and offset-binary bias for the sigmoid operand
  always_comb begin
    w_ext    = PW'(w_data);
    x_ext    = PW'(elem);
    prod     = w_ext * x_ext;
    acc_sum  = acc + AW'(prod);
    acc_wide = CW'(acc_sum);
    if (acc_wide > SAT_MAX) begin
      sat_val = SAT_MAX;
    end else if (acc_wide < SAT_MIN) begin
      sat_val = SAT_MIN;
    end else begin
      sat_val = acc_wide;
    end
    // Adding 2^(WIDTH_SM-1) to a two's-complement value flips its MSB
    sig_next = {~sat_val[WIDTH_SM-1], sat_val[WIDTH_SM-2:0]};
  end

  assign last_i = (i_cnt == IW'(LENGHT_I - 1));
  assign last_o = (o_cnt == OW'(LENGHT_O - 1));

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_reg    <= '0;
      i_cnt     <= '0;
      o_cnt     <= '0;
      acc       <= '0;
      rd_valid  <= 1'b0;
      rd_idx    <= '0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      sig_x     <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Read data is valid one cycle after the strobe
      rd_valid <= w_rd_en;
      rd_idx   <= i_cnt;
      done     <= 1'b0;
      if (abort_hit) begin
        state   <= S_IDLE;
        w_rd_en <= 1'b0;
        sig_x   <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              in_reg    <= in_vec;
              i_cnt     <= '0;
              o_cnt     <= '0;
              acc       <= '0;
              out_valid <= 1'b0;
              w_rd_en   <= 1'b1;
              w_addr    <= '0;
              busy      <= 1'b1;
              state     <= S_MAC;
            end
          end
          S_MAC: begin
            if (rd_valid) begin
              acc <= acc_sum;
            end
            if (last_i) begin
              w_rd_en <= 1'b0;
              state   <= S_DRAIN;
            end else begin
              i_cnt  <= i_cnt + 1'b1;
              w_addr <= w_addr + 1'b1;
            end
          end
          S_DRAIN: begin
            // Last weight arrives now; the biased sum is presented during ACT
            acc   <= acc_sum;
            sig_x <= sig_next;
            state <= S_ACT;
          end
          S_ACT: begin
            for (int k = 0; k < LENGHT_O; k++) begin
              if (o_cnt == OW'(k)) begin
                out_vec[k*WIDTH_O +: WIDTH_O] <= sig_f;
              end
            end
            sig_x <= '0;
            if (last_o) begin
              state <= S_DONE;
            end else begin
              o_cnt   <= o_cnt + 1'b1;
              i_cnt   <= '0;
              acc     <= '0;
              w_rd_en <= 1'b1;
              w_addr  <= w_addr + 1'b1;
              state   <= S_MAC;
            end
          end
          S_DONE: begin
            done      <= 1'b1;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
          default: begin
            state   <= S_IDLE;
            w_rd_en <= 1'b0;
            sig_x   <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb_layer_scheduler
// Directed bench for layer_scheduler: one single-neuron instance (2 inputs,
// 1 output) and one three-neuron instance (2 inputs, 3 outputs), each with a
// synchronous weight memory and a combinational sigmoid stand-in.
module tb_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Single-neuron instance signals
  logic        start_a;
  logic [1:0]  in_a;
  logic        rd_a;
  logic [0:0]  addr_a;
  logic signed [8:0] wd_a;
  logic [7:0]  sx_a;
  logic [9:0]  sf_a;
  logic [9:0]  out_a;
  logic        ov_a, busy_a, done_a;

  // Three-neuron instance signals
  logic        start_b;
  logic [1:0]  in_b;
  logic        rd_b;
  logic [2:0]  addr_b;
  logic signed [8:0] wd_b;
  logic [7:0]  sx_b;
  logic [9:0]  sf_b;
  logic [29:0] out_b;
  logic        ov_b, busy_b, done_b;

  logic signed [8:0] mem_a [2];
  logic signed [8:0] mem_b [6];

  int n_checks = 0;
  int n_errors = 0;
  int exp_sx [3];

  always #5 clk = ~clk;

  // Sigmoid stand-in: any fixed mapping lets the bench predict out_vec
  function automatic logic [9:0] sig_model(input logic [7:0] x);
    int t;
    t = int'(x) * 3 + 7;
    return 10'(t);
  endfunction

  assign sf_a = sig_model(sx_a);
  assign sf_b = sig_model(sx_b);

  always @(posedge clk) begin
    if (rd_a) wd_a <= mem_a[addr_a];
    if (rd_b) wd_b <= (addr_b < 3'd6) ? mem_b[addr_b] : 9'sd0;
  end

  layer_scheduler #(.LENGHT_I(2), .LENGHT_O(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef LAYER_SCHED_ABORT_EN
    .abort(1'b0),
`endif
    .in_vec(in_a), .w_rd_en(rd_a), .w_addr(addr_a), .w_data(wd_a),
    .sig_x(sx_a), .sig_f(sf_a), .out_vec(out_a), .out_valid(ov_a),
    .busy(busy_a), .done(done_a)
  );

  layer_scheduler #(.LENGHT_I(2), .LENGHT_O(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef LAYER_SCHED_ABORT_EN
    .abort(1'b0),
`endif
    .in_vec(in_b), .w_rd_en(rd_b), .w_addr(addr_b), .w_data(wd_b),
    .sig_x(sx_b), .sig_f(sf_b), .out_vec(out_b), .out_valid(ov_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_in(input int which, input logic [1:0] v);
    if (which == 0) in_a = v; else in_b = v;
  endtask

  // One layer evaluation; cycle c is the cycle that begins c edges after the
  // edge that samples start. Neuron n: MAC at 4n,4n+1, DRAIN 4n+2, ACT 4n+3.
  task automatic run_layer(input int which, input string tag, input int lo,
                           input logic [1:0] inv, input int pulse_c, input bit hold);
    int done_cnt, done_c, last_c, n, ph, addr, sx;
    logic rd, dn, ov, bz;
    logic [9:0] slot;
    done_cnt = 0;
    done_c   = -1;
    last_c   = lo * 4 + 2;
    set_in(which, inv);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, hold);
    set_in(which, ~inv);  // must not affect the running evaluation
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) begin
        @(negedge clk);
        set_start(which, hold || (c == pulse_c));
      end
      rd   = (which == 0) ? rd_a : rd_b;
      addr = (which == 0) ? int'(addr_a) : int'(addr_b);
      sx   = (which == 0) ? int'(sx_a) : int'(sx_b);
      dn   = (which == 0) ? done_a : done_b;
      ov   = (which == 0) ? ov_a : ov_b;
      bz   = (which == 0) ? busy_a : busy_b;
      n    = c / 4;
      ph   = c % 4;
      if (c < lo * 4) begin
        if (ph < 2)
          check($sformatf("%s_c%0d_rd_addr", tag, c), {15'd0, rd, 16'(addr)}, {15'd0, 1'b1, 16'(n * 2 + ph)});
        else
          check($sformatf("%s_c%0d_rd_off", tag, c), 32'(rd), 32'd0);
        if (ph == 3)
          check($sformatf("%s_c%0d_sig_x", tag, c), 32'(sx), 32'(exp_sx[n]));
      end
      if (dn) begin
        done_cnt++;
        done_c = c;
      end
      if (c == lo * 4)
        check($sformatf("%s_pre_valid_busy", tag), {30'd0, ov, bz}, 32'b01);
      if (c == lo * 4 + 1)
        check($sformatf("%s_post_valid_busy", tag), {30'd0, ov, bz}, 32'b10);
      if (c == last_c) begin
        if (hold)
          check($sformatf("%s_restart", tag), {14'd0, bz, rd, 16'(addr)}, {14'd0, 1'b1, 1'b1, 16'd0});
        else
          check($sformatf("%s_idle", tag), 32'(bz), 32'd0);
      end
    end
    check($sformatf("%s_done_count", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s_done_cycle", tag), 32'(done_c), 32'(lo * 4 + 1));
    for (int k = 0; k < lo; k++) begin
      slot = (which == 0) ? out_a : out_b[k*10 +: 10];
      check($sformatf("%s_out%0d", tag, k), 32'(slot), 32'(sig_model(8'(exp_sx[k]))));
    end
    $display("run %s: neurons=%0d done_cycle=%0d sig_x0=%0d", tag, lo, done_c, exp_sx[0]);
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    start_a = 1'b0; start_b = 1'b0; in_a = '0; in_b = '0;
    #3;
    check("reset_a_outs", {20'd0, rd_a, addr_a, sx_a, ov_a, busy_a, done_a}, 32'd0);
    check("reset_a_vec", 32'(out_a), 32'd0);
    check("reset_b_outs", {18'd0, rd_b, addr_b, sx_b, ov_b, busy_b, done_b}, 32'd0);
    check("reset_b_vec", 32'(out_b), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Nominal: 10 + 20 = 30 -> 30 + 128 = 158
    mem_a[0] = 9'sd10; mem_a[1] = 9'sd20; exp_sx[0] = 158;
    run_layer(0, "nominal", 1, 2'b11, -1, 1'b0);
    // Positive saturation: 400 clamps to 127 -> 255
    mem_a[0] = 9'sd200; mem_a[1] = 9'sd200; exp_sx[0] = 255;
    run_layer(0, "sat_pos", 1, 2'b11, -1, 1'b0);
    // Negative saturation: -512 clamps to -128 -> 0
    mem_a[0] = -9'sd256; mem_a[1] = -9'sd256; exp_sx[0] = 0;
    run_layer(0, "sat_neg", 1, 2'b11, -1, 1'b0);
    // Masked input: only element 0 set -> -5 -> 123
    mem_a[0] = -9'sd5; mem_a[1] = 9'sd100; exp_sx[0] = 123;
    run_layer(0, "masked", 1, 2'b01, -1, 1'b0);

    // Three neurons, both inputs set: 30, 400, -10 -> 158, 255, 118
    mem_b[0] = 9'sd10;  mem_b[1] = 9'sd20;
    mem_b[2] = 9'sd200; mem_b[3] = 9'sd200;
    mem_b[4] = -9'sd3;  mem_b[5] = -9'sd7;
    exp_sx[0] = 158; exp_sx[1] = 255; exp_sx[2] = 118;
    run_layer(1, "multi_11", 3, 2'b11, -1, 1'b0);
    // Three neurons, element 1 only: -40, 127, 0 -> 88, 255, 128
    mem_b[0] = 9'sd50;   mem_b[1] = -9'sd40;
    mem_b[2] = -9'sd256; mem_b[3] = 9'sd127;
    mem_b[4] = 9'sd1;    mem_b[5] = 9'sd0;
    exp_sx[0] = 88; exp_sx[1] = 255; exp_sx[2] = 128;
    run_layer(1, "multi_10", 3, 2'b10, -1, 1'b0);

    // Start pulsed during a run is ignored
    mem_a[0] = 9'sd10; mem_a[1] = 9'sd20; exp_sx[0] = 158;
    run_layer(0, "busy_pulse", 1, 2'b11, 2, 1'b0);

    // Start held through DONE: a second run begins and captures the new in_vec (00)
    mem_a[0] = 9'sd1; mem_a[1] = 9'sd2; exp_sx[0] = 131;
    run_layer(0, "hold_start", 1, 2'b11, -1, 1'b1);
    start_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    check("hold_second_done", 32'(seen), 32'd1);
    check("hold_second_out", 32'(out_a), 32'(sig_model(8'd128)));
    $display("run hold_second: done_seen=%0d", seen);
    @(negedge clk);

    // Reset in the middle of MAC
    mem_a[0] = 9'sd7; mem_a[1] = 9'sd7;
    in_a = 2'b11; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_a_outs", {20'd0, rd_a, addr_a, sx_a, ov_a, busy_a, done_a}, 32'd0);
    check("midrst_a_vec", 32'(out_a), 32'd0);
    check("midrst_b_vec", 32'(out_b), 32'd0);
    @(negedge clk);
    check("midrst_held_busy", {30'd0, busy_a, rd_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("run midrst: reset applied during MAC");
    mem_a[0] = 9'sd10; mem_a[1] = 9'sd20; exp_sx[0] = 158;
    run_layer(0, "after_rst", 1, 2'b11, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
